// File: rtl/instr_fetch_sequencer_if.sv
// Fetch/issue bus of the RISC-8 instruction fetch sequencer.
// Instruction-memory side: imem_req, imem_addr (to memory), imem_ack, imem_rdata (from memory).
// Decode/datapath side: instr_valid, instr, opcode, pc_out (to decode);
// instr_done, branch, jump, branch_taken, target (retire outcome from datapath).
// master = sequencer, slave = memory + decode/datapath.
interface instr_fetch_sequencer_if #(
    parameter int unsigned PC_W    = 8,
    parameter int unsigned INSTR_W = 16
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic [3:0]         opcode;
    logic [PC_W-1:0]    pc_out;
    logic               instr_done;
    logic               branch;
    logic               jump;
    logic               branch_taken;
    logic [PC_W-1:0]    target;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, opcode, pc_out,
        input  imem_ack, imem_rdata, instr_done, branch, jump, branch_taken, target
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, opcode, pc_out,
        output imem_ack, imem_rdata, instr_done, branch, jump, branch_taken, target
    );
endinterface

// File: rtl/instr_fetch_sequencer.sv
// Multi-cycle instruction fetch and sequencing unit for the RISC-8 core.
// Owns the PC, fetches one instruction per step over a req/ack handshake, holds it in the
// instruction register for decode, and forms the next PC from the retire outcome.
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - synchronous active-low reset
//   en     - run enable, sampled in IDLE and at retire
//   bus    - fetch/issue bus (master side), see instr_fetch_sequencer_if
//   halted - sequencer stopped after retiring HALT_OP
module instr_fetch_sequencer #(
    parameter int unsigned     PC_W     = 8,
    parameter int unsigned     INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [3:0]      HALT_OP  = 4'b1111
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    instr_fetch_sequencer_if.master  bus,
    output logic                     halted
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] ISSUE = 2'd2;
    localparam logic [1:0] HALT  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    pc_out_q, pc_out_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [3:0]         opcode;

    assign opcode = instr_q[INSTR_W-1 -: 4];

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pc_out_d = pc_out_q;
        instr_d  = instr_q;
        unique case (state_q)
            IDLE: begin
                if (en) state_d = FETCH;
            end
            FETCH: begin
                if (bus.imem_ack) begin
                    instr_d  = bus.imem_rdata;
                    pc_out_d = pc_q;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                // Branch/jump inputs only matter on the retire edge.
                if (bus.instr_done) begin
                    if (bus.jump) begin
                        pc_d = bus.target;
                    end else if (bus.branch && bus.branch_taken) begin
                        pc_d = bus.target;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                    if (opcode == HALT_OP) begin
                        state_d = HALT;
                    end else if (en) begin
                        state_d = FETCH;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            pc_out_q <= RESET_PC;
            instr_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc_out_q <= pc_out_d;
            instr_q  <= instr_d;
        end
    end

    // imem_addr tracks pc in every state; memory only looks at it while imem_req is high.
    assign bus.imem_req    = (state_q == FETCH);
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = (state_q == ISSUE);
    assign bus.instr       = instr_q;
    assign bus.opcode      = opcode;
    assign bus.pc_out      = pc_out_q;
    assign halted          = (state_q == HALT);

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
module tb_instr_fetch_sequencer;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
        int          req_len;   // expected imem_req cycles, -1 = not checked
        bit          b2b;       // fetch must start the cycle after instr_valid
    } exp_t;

    logic clk;
    logic rst_n;
    logic en;
    logic halted;

    instr_fetch_sequencer_if #(.PC_W(8), .INSTR_W(16)) bus ();

    instr_fetch_sequencer #(
        .PC_W    (8),
        .INSTR_W (16),
        .RESET_PC(8'h00),
        .HALT_OP (4'b1111)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .bus   (bus.master),
        .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    bit   mon_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per fetch and checks the issued instruction against it.
    initial begin
        exp_t cur;
        logic req_prev, valid_prev;
        int   req_len, valid_len;
        cur = '{addr: 8'h00, data: 16'h0000, req_len: -1, b2b: 1'b0};
        req_prev = 1'b0;
        valid_prev = 1'b0;
        req_len = 0;
        valid_len = 0;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                chk("req_valid_exclusive", 32'(bus.imem_req && bus.instr_valid), 32'd0);
                if (bus.imem_req && !req_prev) begin
                    req_len = 0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_fetch: got addr %0h expected no request at %0t",
                                 bus.imem_addr, $time);
                        cur = '{addr: bus.imem_addr, data: 16'h0000, req_len: -1, b2b: 1'b0};
                    end else begin
                        cur = exp_q.pop_front();
                        chk("fetch_addr", 32'(bus.imem_addr), 32'(cur.addr));
                        if (cur.b2b) chk("fetch_after_retire", 32'(valid_prev), 32'd1);
                    end
                end
                if (bus.imem_req) begin
                    req_len++;
                    chk("addr_stable", 32'(bus.imem_addr), 32'(cur.addr));
                end
                if (!bus.imem_req && req_prev && cur.req_len >= 0)
                    chk("req_len", 32'(req_len), 32'(cur.req_len));
                if (bus.instr_valid && !valid_prev) begin
                    valid_len = 0;
                    chk("valid_after_ack", 32'(req_prev), 32'd1);
                    chk("instr", 32'(bus.instr), 32'(cur.data));
                    chk("opcode", 32'(bus.opcode), 32'(cur.data[15:12]));
                    chk("pc_out", 32'(bus.pc_out), 32'(cur.addr));
                end
                if (bus.instr_valid) valid_len++;
                if (!bus.instr_valid && valid_prev) chk("valid_len", 32'(valid_len), 32'd1);
            end
            req_prev   = bus.imem_req;
            valid_prev = bus.instr_valid;
        end
    end

    // One instruction: answer the fetch after w wait cycles, then retire it the next cycle.
    task automatic run_instr(input logic [7:0] addr, input logic [15:0] data, input int w,
                             input logic br, input logic jp, input logic tk,
                             input logic [7:0] tgt, input logic en_r, input bit b2b);
        bit seen;
        exp_q.push_back('{addr: addr, data: data, req_len: w + 1, b2b: b2b});
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.imem_req) seen = 1'b1;
        end
        if (!seen) begin
            chk("fetch_timeout", 32'(bus.imem_req), 32'd1);
            return;
        end
        repeat (w) @(negedge clk);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = data;
        @(posedge clk);
        #1;
        bus.imem_ack     = 1'b0;
        bus.imem_rdata   = 16'h0000;
        bus.instr_done   = 1'b1;
        bus.branch       = br;
        bus.jump         = jp;
        bus.branch_taken = tk;
        bus.target       = tgt;
        en               = en_r;
        @(posedge clk);
        #1;
        bus.instr_done   = 1'b0;
        bus.branch       = 1'b0;
        bus.jump         = 1'b0;
        bus.branch_taken = 1'b0;
        bus.target       = 8'h00;
    endtask

    initial begin
        int bad;
        rst_n            = 1'b0;
        en               = 1'b0;
        bus.imem_ack     = 1'b0;
        bus.imem_rdata   = 16'h0000;
        bus.instr_done   = 1'b0;
        bus.branch       = 1'b0;
        bus.jump         = 1'b0;
        bus.branch_taken = 1'b0;
        bus.target       = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_instr", 32'(bus.instr), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_addr", 32'(bus.imem_addr), 32'h00);
        mon_on = 1'b1;

        en = 1'b1;
        run_instr(8'h00, 16'h1234, 0, 0, 0, 0, 8'h00, 1, 0);
        run_instr(8'h01, 16'h2345, 0, 0, 0, 0, 8'h00, 1, 1);
        run_instr(8'h02, 16'h3456, 0, 0, 0, 0, 8'h00, 1, 1);
        run_instr(8'h03, 16'h4001, 0, 0, 0, 0, 8'h00, 1, 1);
        run_instr(8'h04, 16'h5002, 0, 0, 0, 0, 8'h00, 1, 1);
        run_instr(8'h05, 16'h6003, 3, 0, 0, 0, 8'h00, 1, 1);   // 3 wait cycles
        run_instr(8'h06, 16'h7004, 0, 0, 1, 0, 8'h10, 1, 1);   // jump to 0x10
        run_instr(8'h10, 16'h8005, 0, 1, 0, 0, 8'h40, 1, 1);   // branch not taken
        run_instr(8'h11, 16'h9006, 0, 1, 0, 1, 8'h40, 1, 1);   // branch taken
        run_instr(8'h40, 16'hA007, 0, 1, 1, 1, 8'h22, 1, 1);   // jump wins
        run_instr(8'h22, 16'hB008, 0, 0, 1, 0, 8'hFF, 1, 1);   // jump to 0xFF
        run_instr(8'hFF, 16'hC009, 0, 0, 0, 0, 8'h00, 1, 1);   // pc wraps
        run_instr(8'h00, 16'hD00A, 0, 0, 0, 0, 8'h00, 0, 1);   // retire with en=0

        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.imem_req !== 1'b0) bad++;
        end
        chk("idle_no_req", 32'(bad), 32'd0);
        chk("idle_pc", 32'(bus.imem_addr), 32'h01);

        en = 1'b1;
        run_instr(8'h01, 16'hE00B, 0, 0, 1, 0, 8'h30, 1, 0);   // resume, jump to 0x30

        // Fetch at 0x30 is abandoned by reset; a late ack must be ignored.
        exp_q.push_back('{addr: 8'h30, data: 16'h0000, req_len: -1, b2b: 1'b1});
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        en    = 1'b0;
        @(posedge clk);
        #1;
        rst_n          = 1'b1;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 16'h5555;
        @(posedge clk);
        #1;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 16'h0000;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0) bad++;
        end
        chk("late_ack_ignored", 32'(bad), 32'd0);
        chk("post_rst_pc", 32'(bus.imem_addr), 32'h00);

        en = 1'b1;
        run_instr(8'h00, 16'h600C, 0, 0, 1, 0, 8'h07, 1, 0);   // jump to 0x07
        run_instr(8'h07, 16'hF000, 0, 0, 0, 0, 8'h00, 1, 1);   // HALT_OP

        chk("halted", 32'(halted), 32'd1);
        chk("halt_pc", 32'(bus.imem_addr), 32'h08);
        chk("halt_valid", 32'(bus.instr_valid), 32'd0);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.imem_req !== 1'b0 || halted !== 1'b1) bad++;
        end
        chk("halt_stays", 32'(bad), 32'd0);
        chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instr_fetch_sequencer.md
Name: instr_fetch_sequencer

Overview:
Multi-cycle instruction fetch and sequencing unit for the RISC-8 core; it supplies the opcode that the control unit decodes.
- Owns the PC and fetches one instruction per step from instruction memory over a req/ack handshake.
- Holds each instruction in an instruction register and presents it, with the PC, to decode/datapath.
- On retire, takes the datapath's branch/jump outcome and forms the next PC.

Parameters:
PC_W, 8, PC and instruction-address width.
INSTR_W, 16, instruction width; opcode is instr[INSTR_W-1:INSTR_W-4].
RESET_PC, 0, PC value after reset.
HALT_OP, 4'b1111, opcode that stops sequencing after it retires.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
rst_n  in  1  reset, synchronous and active-low.
en  in  1  run enable; sampled in IDLE and at retire.
imem_req  out  1  fetch request to instruction memory.
imem_addr  out  PC_W  fetch address; equals pc while imem_req=1.
imem_ack  in  1  memory response valid; qualifies imem_rdata.
imem_rdata  in  INSTR_W  fetched instruction.
instr_valid  out  1  instr/opcode/pc_out hold a live instruction.
instr  out  INSTR_W  instruction register contents.
opcode  out  4  instr[INSTR_W-1:INSTR_W-4], routed to the control unit.
pc_out  out  PC_W  address of the instruction in instr.
instr_done  in  1  datapath has retired the current instruction.
branch  in  1  current instruction is a conditional branch.
jump  in  1  current instruction is an unconditional jump.
branch_taken  in  1  branch condition true.
target  in  PC_W  branch/jump destination.
halted  out  1  sequencer stopped on HALT_OP.

Behaviour:
Reset (rst_n=0 at an edge, in any state):
- state=IDLE, pc=RESET_PC.
- imem_req=0, instr_valid=0, instr=0, halted=0.
- Any outstanding fetch is abandoned. A late imem_ack is ignored because it is only honoured in FETCH.

States:
- IDLE: all outputs quiescent. en=1 -> FETCH next edge.
- FETCH: imem_req=1, imem_addr=pc, both held stable until ack.
  - On an edge with imem_ack=1: instr<=imem_rdata, pc_out<=pc, go ISSUE.
  - imem_req drops the same edge. Zero-wait ack (ack in first FETCH cycle) is legal.
- ISSUE: instr_valid=1, and instr/opcode/pc_out stay stable until retire.
  - On an edge with instr_done=1, next pc is chosen by priority:
    - jump=1 -> target
    - else branch=1 and branch_taken=1 -> target
    - else pc+1, modulo 2^PC_W (0xFF wraps to 0x00).
  - branch/jump/branch_taken/target are sampled only on that retire edge.
  - instr_valid drops that edge.
  - Next state: opcode==HALT_OP -> HALT; else en=1 -> FETCH; else IDLE.
- HALT: halted=1, imem_req=0, instr_valid=0, pc holds its updated value. Exit only via reset.

Timing:
- imem_ack and instr_done are ignored outside FETCH and ISSUE respectively.
- Retire at edge N -> imem_req=1 with the new address from cycle N+1.
- imem_ack at edge M -> instr_valid=1 from cycle M+1.
- Minimum 2 cycles per instruction (one FETCH, one ISSUE).

Invariants:
- imem_req and instr_valid are never both 1.
- No X on any output after reset.

Test Plan:
- Reset then en=1, memory acks every request in its first cycle, rdata 0x1234/0x2345/0x3456, instr_done one cycle after each instr_valid -> imem_addr 0x00,0x01,0x02; opcode 1,2,3; pc_out matches; 2 cycles per instruction.
- Ack delayed 3 cycles at addr 0x05 -> imem_req and imem_addr=0x05 stable for 4 cycles; instr_valid rises the cycle after ack.
- At pc 0x10: branch=1, branch_taken=0 -> next fetch 0x11. Then branch=1, branch_taken=1, target=0x40 -> next fetch 0x40. Then jump=1, branch=1, branch_taken=1, target=0x22 -> next fetch 0x22.
- pc=0xFF, plain instruction retires -> next imem_addr 0x00.
- Fetch returns opcode 4'b1111 at 0x07 and retires -> halted=1 from next cycle; no further imem_req over 20 cycles; pc=0x08.
- rst_n=0 for one edge during a FETCH wait at 0x30, then imem_ack=1 the following cycle -> ack ignored, instr_valid stays 0, next fetch (en=1) is at RESET_PC.
- en=0 when an instruction retires -> IDLE, imem_req=0; later en=1 -> fetch resumes at the updated pc.
